// File: rtl/ddr_ctrl_csr_gen.sv
// DDR control-domain CSR file: double-buffered config, sampled status, sticky events.
// Optional CTRL.LOCK bit enabled by defining DDR_CTRL_CSR_LOCK_EN.
module ddr_ctrl_csr_gen #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int NUM_CFG = 4,
  parameter int NUM_STA = 2,
  parameter logic [NUM_CFG*DWIDTH-1:0] CFG_POR = '0,
  parameter logic [DWIDTH-1:0] EVT_EN_POR = '0
) (
  input  logic                      i_hclk,
  input  logic                      i_hreset,
  input  logic                      i_write,
  input  logic                      i_read,
  input  logic [AWIDTH-1:0]         i_addr,
  input  logic [DWIDTH-1:0]         i_wdata,
  input  logic [DWIDTH/8-1:0]       i_wstrb,
  output logic [DWIDTH-1:0]         o_rdata,
  output logic                      o_error,
  output logic                      o_ready,
  input  logic                      i_update,
  output logic [NUM_CFG*DWIDTH-1:0] o_cfg,
  input  logic [NUM_STA*DWIDTH-1:0] i_sta,
  input  logic [DWIDTH-1:0]         i_evt,
  output logic                      o_irq
);

  localparam int SW = DWIDTH / 8;
  localparam int WW = AWIDTH - 2;

  typedef logic [WW-1:0] widx_t;

  localparam widx_t CFG_END = widx_t'(NUM_CFG);
  localparam widx_t EVT_A   = widx_t'(NUM_CFG + NUM_STA);
  localparam widx_t EN_A    = widx_t'(NUM_CFG + NUM_STA + 1);
  localparam widx_t CTL_A   = widx_t'(NUM_CFG + NUM_STA + 2);
  localparam widx_t MAP_END = widx_t'(NUM_CFG + NUM_STA + 3);

  logic [DWIDTH-1:0] shadow_q [NUM_CFG];
  logic [DWIDTH-1:0] shadow_d [NUM_CFG];
  logic [DWIDTH-1:0] active_q [NUM_CFG];
  logic [DWIDTH-1:0] active_d [NUM_CFG];
  logic [DWIDTH-1:0] sta_q [NUM_STA];
  logic [DWIDTH-1:0] sta_d [NUM_STA];
  logic [DWIDTH-1:0] evt_q, evt_d;
  logic [DWIDTH-1:0] evt_en_q, evt_en_d;
  logic              irq_q, irq_d;
  logic              locked;

  widx_t             w;
  logic              acc, mis, mapped;
  logic              hit_cfg, hit_sta, hit_evt, hit_en, hit_ctl;
  logic              upd_bit, lock_err, err, we;
  logic [DWIDTH-1:0] bmask;

  // Address decode, byte-lane mask and access error
  always_comb begin
    w        = i_addr[AWIDTH-1:2];
    acc      = i_read | i_write;
    mis      = i_addr[1:0] != 2'b00;
    mapped   = w < MAP_END;
    hit_cfg  = w < CFG_END;
    hit_sta  = (w >= CFG_END) && (w < EVT_A);
    hit_evt  = w == EVT_A;
    hit_en   = w == EN_A;
    hit_ctl  = w == CTL_A;
    upd_bit  = i_wdata[0] & i_wstrb[0];
    bmask    = '0;
    for (int b = 0; b < SW; b++) begin
      bmask[b*8 +: 8] = {8{i_wstrb[b]}};
    end
    lock_err = locked & i_write
             & (hit_cfg | hit_en | (hit_ctl & upd_bit));
    err      = acc & (~mapped | mis
             | (i_write & hit_sta) | lock_err);
    we       = i_write & ~err;
  end

  // Combinational read mux; zero when idle or errored
  always_comb begin
    o_rdata = '0;
    if (i_read && !err) begin
      for (int k = 0; k < NUM_CFG; k++) begin
        if (w == widx_t'(k)) o_rdata = shadow_q[k];
      end
      for (int s = 0; s < NUM_STA; s++) begin
        if (w == widx_t'(NUM_CFG + s)) o_rdata = sta_q[s];
      end
      if (hit_evt) o_rdata = evt_q;
      if (hit_en)  o_rdata = evt_en_q;
      if (hit_ctl) o_rdata[1] = locked;
    end
  end

  // Next-state for config, status, events and interrupt
  always_comb begin
    logic [DWIDTH-1:0] clr;
    logic              upd;
    clr      = '0;
    upd      = i_update;
    evt_en_d = evt_en_q;
    for (int k = 0; k < NUM_CFG; k++) begin
      shadow_d[k] = shadow_q[k];
      active_d[k] = active_q[k];
    end
    if (we) begin
      for (int k = 0; k < NUM_CFG; k++) begin
        if (w == widx_t'(k)) begin
          shadow_d[k] = (shadow_q[k] & ~bmask) | (i_wdata & bmask);
        end
      end
      if (hit_evt) clr = i_wdata & bmask;
      if (hit_en)  evt_en_d = (evt_en_q & ~bmask) | (i_wdata & bmask);
      if (hit_ctl && upd_bit) upd = 1'b1;
    end
    if (upd) begin
      for (int k = 0; k < NUM_CFG; k++) active_d[k] = shadow_q[k];
    end
    for (int s = 0; s < NUM_STA; s++) begin
      sta_d[s] = i_sta[s*DWIDTH +: DWIDTH];
    end
    evt_d = (evt_q & ~clr) | i_evt;
    irq_d = |(evt_q & evt_en_q);
  end

  // Register state
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      for (int k = 0; k < NUM_CFG; k++) begin
        shadow_q[k] <= CFG_POR[k*DWIDTH +: DWIDTH];
        active_q[k] <= CFG_POR[k*DWIDTH +: DWIDTH];
      end
      for (int s = 0; s < NUM_STA; s++) sta_q[s] <= '0;
      evt_q    <= '0;
      evt_en_q <= EVT_EN_POR;
      irq_q    <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CFG; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
      for (int s = 0; s < NUM_STA; s++) sta_q[s] <= sta_d[s];
      evt_q    <= evt_d;
      evt_en_q <= evt_en_d;
      irq_q    <= irq_d;
    end
  end

`ifdef DDR_CTRL_CSR_LOCK_EN
  logic lock_q, lock_d;

  // Sticky lock, set by CTRL bit1
  always_comb begin
    lock_d = lock_q | (we & hit_ctl & i_wdata[1] & i_wstrb[0]);
  end

  // Lock register
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) lock_q <= 1'b0;
    else          lock_q <= lock_d;
  end

  assign locked = lock_q;
`else
  assign locked = 1'b0;
`endif

  // Active config packing
  always_comb begin
    o_cfg = '0;
    for (int k = 0; k < NUM_CFG; k++) begin
      o_cfg[k*DWIDTH +: DWIDTH] = active_q[k];
    end
  end

  assign o_error = err;
  assign o_ready = 1'b1;
  assign o_irq   = irq_q;

endmodule
